// File: rtl/ptc_tap_encoder_if.sv
`default_nettype none
// ============================================================================
// Module   : ptc_tap_encoder_if
// Purpose  : Bundles the sample-in and code-out handshakes of the PTC tap
//            encoder into one interface.
// Signals  : in_valid/in_ready  - sample handshake (t_in, fine_in)
//            out_valid/out_ready - code handshake (q_out)
//            err                 - one-cycle pulse on an illegal accepted t_in
// Modports : master - sample producer / code consumer
//            slave  - the encoder
// Revision : 1.0 - initial release
// ============================================================================
interface ptc_tap_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] t_in;
  logic [5:0]  fine_in;
  logic        out_valid;
  logic        out_ready;
  logic [9:0]  q_out;
  logic        err;

  modport master (
    output in_valid, t_in, fine_in, out_ready,
    input  in_ready, out_valid, q_out, err
  );

  modport slave (
    input  in_valid, t_in, fine_in, out_ready,
    output in_ready, out_valid, q_out, err
  );
endinterface
`default_nettype wire

// File: rtl/ptc_tap_encoder.sv
`default_nettype none
// ============================================================================
// Module   : ptc_tap_encoder
// Purpose  : Converts a one-hot coarse tap vector plus a fine tap code into a
//            10-bit code, emitting it only after STABLE_CNT consecutive
//            identical legal samples and only when it differs from the last
//            code emitted (the first code after reset is always emitted).
// Ports    : clk    - rising-edge clock
//            rst_n  - synchronous active-low reset
//            bus    - ptc_tap_encoder_if.slave (sample in, code out, err)
// Params   : STABLE_CNT - matching samples needed before emission (1..15)
// Revision : 1.0 - initial release
// ============================================================================
module ptc_tap_encoder #(
  parameter int STABLE_CNT = 3
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  ptc_tap_encoder_if.slave  bus
);

  localparam logic [3:0]  C_STABLE    = 4'(STABLE_CNT);
  localparam logic [9:0]  C_RESET_CW  = 10'b0001_000000;

  typedef enum logic [0:0] {
    S_FILTER = 1'b0,
    S_OUT    = 1'b1
  } state_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [9:0]  cand_q;
  logic [9:0]  q_out_q;
  logic [9:0]  last_q;
  logic        first_q;
  logic        out_valid_q;
  logic        err_q;

  logic [3:0]  coarse_w;
  logic        illegal_w;
  logic [9:0]  cand_w;
  logic [3:0]  cnt_d;
  logic        emit_w;
  logic        accept_w;

  // Inverse of the 4-to-16 decoder: bit k maps to code k+1, no bit to 0.
  // Multiple set bits are caught by the x & (x-1) test; bit 15 has no code.
  always_comb begin
    coarse_w = 4'd0;
    for (int k = 0; k < 15; k++) begin
      if (bus.t_in[k]) coarse_w = 4'(k + 1);
    end
    illegal_w = (|(bus.t_in & (bus.t_in - 16'd1))) | bus.t_in[15];
    cand_w    = {coarse_w, bus.fine_in};
    if (cand_w == cand_q) begin
      cnt_d = (cnt_q == C_STABLE) ? cnt_q : cnt_q + 4'd1;
    end else begin
      cnt_d = 4'd1;
    end
    // A saturated count with a candidate equal to the last code never emits,
    // so no "just reached" edge detection is needed here.
    emit_w = !illegal_w && (cnt_d == C_STABLE) &&
             ((cand_w != last_q) || first_q);
  end

  // in_ready comes from the registered state; gating with rst_n holds it low
  // while reset is asserted and releases it in the first cycle afterwards.
  assign accept_w      = bus.in_valid && bus.in_ready;
  assign bus.in_ready  = rst_n && (state_q == S_FILTER);
  assign bus.out_valid = out_valid_q;
  assign bus.q_out     = q_out_q;
  assign bus.err       = err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_FILTER;
      cnt_q       <= 4'd0;
      cand_q      <= C_RESET_CW;
      q_out_q     <= C_RESET_CW;
      last_q      <= C_RESET_CW;
      first_q     <= 1'b1;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        S_FILTER: begin
          if (accept_w) begin
            if (illegal_w) begin
              // Illegal sample breaks the run but keeps the stored candidate.
              cnt_q <= 4'd0;
              err_q <= 1'b1;
            end else begin
              cand_q <= cand_w;
              cnt_q  <= cnt_d;
              if (emit_w) begin
                q_out_q     <= cand_w;
                last_q      <= cand_w;
                first_q     <= 1'b0;
                out_valid_q <= 1'b1;
                state_q     <= S_OUT;
              end
            end
          end
        end
        S_OUT: begin
          if (bus.out_ready) begin
            cnt_q       <= 4'd0;
            out_valid_q <= 1'b0;
            state_q     <= S_FILTER;
          end
        end
        default: begin
          state_q     <= S_FILTER;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
